// File: rtl/t03_nes_pkg.sv
// Shared types and constants for the NES gamepad poller: FSM states,
// button bit indices and field offsets within the published NESData word.
package t03_nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_DONE
  } nes_state_e;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam int unsigned P1_HELD = 0;
  localparam int unsigned P2_HELD = 8;
  localparam int unsigned P1_NEW  = 16;
  localparam int unsigned P2_NEW  = 24;

endpackage

// File: rtl/t03_nes_controller_if.sv
// Pad-side bus shared by both NES controllers: common latch/clock out,
// one active-low serial data line per pad.
interface t03_nes_controller_if;
  logic nes_latch;
  logic nes_clk;
  logic nes_data1;
  logic nes_data2;

  modport master (output nes_latch, output nes_clk, input nes_data1, input nes_data2);
  modport slave  (input nes_latch, input nes_clk, output nes_data1, output nes_data2);
endinterface

// File: rtl/t03_nes_shift.sv
// Per-pad receive path: 2-FF synchronizer, inversion to 1 = pressed,
// and an 8-bit capture register written at the bit index given by the parent.
module t03_nes_shift (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       data_n,
  input  logic       sample,
  input  logic [2:0] idx,
  output logic [7:0] bits
);

  logic [1:0] sync_q, sync_d;
  logic [7:0] cap_q, cap_d;

  always_comb begin
    sync_d = {sync_q[0], data_n};
    cap_d  = cap_q;
    if (sample) cap_d[idx] = ~sync_q[1];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '1;
      cap_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cap_q  <= cap_d;
    end
  end

  assign bits = cap_q;

endmodule

// File: rtl/t03_nes_controller.sv
// Free-running two-pad NES poller publishing a packed button word plus a
// one-cycle update strobe. Define T03_NES_EDGE_EN to build the new-press fields.
module t03_nes_controller
  import t03_nes_pkg::*;
#(
  parameter int unsigned DIV         = 60,
  parameter int unsigned POLL_CYCLES = 166667
) (
  input  logic                        clk,
  input  logic                        n_rst,
  t03_nes_controller_if.master        pad,
  output logic [31:0]                 NESData,
  output logic                        NESConfirm
);

  localparam int unsigned TW = $clog2(POLL_CYCLES);
  localparam int unsigned PW = $clog2(2 * DIV + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);
  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * DIV - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);

  nes_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]    pulse_q, pulse_d;
  logic          latch_q, latch_d;
  logic          nclk_q, nclk_d;
  logic [31:0]   data_q, data_d;
  logic          confirm_q, confirm_d;

  logic          sample;
  logic [2:0]    idx;
  logic [7:0]    p1_bits, p2_bits;

  t03_nes_shift u_shift1 (
    .clk    (clk),
    .n_rst  (n_rst),
    .data_n (pad.nes_data1),
    .sample (sample),
    .idx    (idx),
    .bits   (p1_bits)
  );

  t03_nes_shift u_shift2 (
    .clk    (clk),
    .n_rst  (n_rst),
    .data_n (pad.nes_data2),
    .sample (sample),
    .idx    (idx),
    .bits   (p2_bits)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pulse_d   = pulse_q;
    latch_d   = latch_q;
    nclk_d    = nclk_q;
    data_d    = data_q;
    confirm_d = 1'b0;
    sample    = 1'b0;
    idx       = '0;
    timer_d   = (timer_q == TIMER_LAST) ? '0 : timer_q + 1'b1;

    // Outputs are registered, so each branch sets the values for the state being entered.
    unique case (state_q)
      ST_IDLE: begin
        if (timer_q == TIMER_LAST) begin
          state_d = ST_LATCH;
          phase_d = '0;
          latch_d = 1'b1;
        end
      end
      ST_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          sample  = 1'b1;
          state_d = ST_CLK_LO;
          phase_d = '0;
          pulse_d = 4'd1;
          latch_d = 1'b0;
          nclk_d  = 1'b0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_CLK_LO: begin
        if (phase_q == PHASE_LAST) begin
          sample  = (pulse_q >= 4'd2);
          idx     = 3'(pulse_q - 4'd1);
          state_d = ST_CLK_HI;
          phase_d = '0;
          nclk_d  = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_CLK_HI: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          if (pulse_q < 4'd8) begin
            pulse_d = pulse_q + 1'b1;
            state_d = ST_CLK_LO;
            nclk_d  = 1'b0;
          end else begin
            state_d   = ST_DONE;
            confirm_d = 1'b1;
            data_d[P1_HELD +: 8] = p1_bits;
            data_d[P2_HELD +: 8] = p2_bits;
`ifdef T03_NES_EDGE_EN
            data_d[P1_NEW +: 8] = p1_bits & ~data_q[P1_HELD +: 8];
            data_d[P2_NEW +: 8] = p2_bits & ~data_q[P2_HELD +: 8];
`else
            data_d[P1_NEW +: 16] = '0;
`endif
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        latch_d = 1'b0;
        nclk_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      phase_q   <= '0;
      pulse_q   <= '0;
      latch_q   <= 1'b0;
      nclk_q    <= 1'b1;
      data_q    <= '0;
      confirm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      phase_q   <= phase_d;
      pulse_q   <= pulse_d;
      latch_q   <= latch_d;
      nclk_q    <= nclk_d;
      data_q    <= data_d;
      confirm_q <= confirm_d;
    end
  end

  assign pad.nes_latch = latch_q;
  assign pad.nes_clk   = nclk_q;
  assign NESData       = data_q;
  assign NESConfirm    = confirm_q;

endmodule

// File: tb/tb_t03_nes_controller.sv
// Directed bench for t03_nes_controller with a behavioural NES pad model on
// each data line; expectations follow the T03_NES_EDGE_EN build setting.
module tb_t03_nes_controller;

  localparam int unsigned DIV  = 4;
  localparam int unsigned POLL = 200;
  localparam int unsigned DONE_OFF = 18 * DIV;

  typedef struct {
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [31:0] nes_data;
  logic        nes_confirm;
  logic [7:0]  btn1 = '0, btn2 = '0;
  logic [7:0]  pad1 = '0, pad2 = '0;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[7];

  t03_nes_controller_if pad_if ();

  t03_nes_controller #(.DIV(DIV), .POLL_CYCLES(POLL)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .pad        (pad_if.master),
    .NESData    (nes_data),
    .NESConfirm (nes_confirm)
  );

  always #5 clk = ~clk;

  // Pad model: parallel load on latch rise, shift toward bit 0 on each clock rise.
  always @(posedge pad_if.nes_latch) begin
    pad1 <= btn1;
    pad2 <= btn2;
  end
  always @(posedge pad_if.nes_clk) begin
    if (!pad_if.nes_latch) begin
      pad1 <= {1'b0, pad1[7:1]};
      pad2 <= {1'b0, pad2[7:1]};
    end
  end
  assign pad_if.nes_data1 = ~pad1[0];
  assign pad_if.nes_data2 = ~pad2[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic exp_latch(input int unsigned off);
    return off < 2 * DIV;
  endfunction

  function automatic logic exp_nclk(input int unsigned off);
    if (off >= 2 * DIV && off < DONE_OFF && ((off - 2 * DIV) % (2 * DIV)) < DIV) return 1'b0;
    return 1'b1;
  endfunction

  // Waits for the next latch rise (counting from start), checks the gap, then
  // checks the full poll waveform and the published word; ends on offset DONE_OFF+7.
  task automatic run_poll(input int unsigned start, input logic [31:0] exp, input string name);
    int unsigned n = start;
    bit seen = 0;
    while (n < POLL + 20 && !seen) begin
      @(negedge clk);
      n++;
      if (pad_if.nes_latch === 1'b1) seen = 1;
    end
    check({name, "_t0_gap"}, n, POLL);
    if (!seen) return;
    for (int unsigned off = 0; off < DONE_OFF + 8; off++) begin
      if (off != 0) @(negedge clk);
      check($sformatf("%s_latch@%0d", name, off), {31'b0, pad_if.nes_latch}, {31'b0, exp_latch(off)});
      check($sformatf("%s_nclk@%0d", name, off), {31'b0, pad_if.nes_clk}, {31'b0, exp_nclk(off)});
      check($sformatf("%s_confirm@%0d", name, off), {31'b0, nes_confirm},
            {31'b0, (off == DONE_OFF)});
      if (off == DONE_OFF || off == DONE_OFF + 7) check({name, "_data"}, nes_data, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef T03_NES_EDGE_EN
    vecs[0] = '{8'h09, 8'h80, 32'h8009_8009};
    vecs[1] = '{8'h09, 8'h80, 32'h0000_8009};
    vecs[2] = '{8'h09, 8'h82, 32'h0200_8209};
    vecs[3] = '{8'h00, 8'h00, 32'h0000_0000};
    vecs[4] = '{8'hFF, 8'h00, 32'h00FF_00FF};
    vecs[5] = '{8'hA5, 8'h3C, 32'h3C00_3CA5};
    vecs[6] = '{8'h5A, 8'hC3, 32'hC35A_C35A};
`else
    vecs[0] = '{8'h09, 8'h80, 32'h0000_8009};
    vecs[1] = '{8'h09, 8'h80, 32'h0000_8009};
    vecs[2] = '{8'h09, 8'h82, 32'h0000_8209};
    vecs[3] = '{8'h00, 8'h00, 32'h0000_0000};
    vecs[4] = '{8'hFF, 8'h00, 32'h0000_00FF};
    vecs[5] = '{8'hA5, 8'h3C, 32'h0000_3CA5};
    vecs[6] = '{8'h5A, 8'hC3, 32'h0000_C35A};
`endif

    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_latch", {31'b0, pad_if.nes_latch}, 32'd0);
    check("rst_nclk", {31'b0, pad_if.nes_clk}, 32'd1);
    check("rst_data", nes_data, 32'd0);
    check("rst_confirm", {31'b0, nes_confirm}, 32'd0);

    btn1 = vecs[0].b1;
    btn2 = vecs[0].b2;
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      btn1 = vecs[i].b1;
      btn2 = vecs[i].b2;
      run_poll((i == 0) ? 0 : DONE_OFF + 7, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset dropped during the low phase of pulse 5 must abort the poll at once.
    begin
      int unsigned n = DONE_OFF + 7;
      int bad = 0;
      bit seen = 0;
      btn1 = 8'h09;
      btn2 = 8'h80;
      while (n < POLL + 20 && !seen) begin
        @(negedge clk);
        n++;
        if (pad_if.nes_latch === 1'b1) seen = 1;
      end
      check("midrst_t0_gap", n, POLL);
      repeat (2 * DIV + 4 * 2 * DIV + 2) @(negedge clk);
      check("midrst_pulse5_low", {31'b0, pad_if.nes_clk}, 32'd0);
      n_rst = 1'b0;
      #1;
      check("midrst_latch", {31'b0, pad_if.nes_latch}, 32'd0);
      check("midrst_nclk", {31'b0, pad_if.nes_clk}, 32'd1);
      check("midrst_data", nes_data, 32'd0);
      check("midrst_confirm", {31'b0, nes_confirm}, 32'd0);
      repeat (50) begin
        @(negedge clk);
        if (nes_confirm !== 1'b0 || pad_if.nes_latch !== 1'b0 || pad_if.nes_clk !== 1'b1) bad++;
      end
      check("midrst_held_quiet", bad, 0);
      n_rst = 1'b1;
      run_poll(0, vecs[0].exp, "after_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/t03_nes_controller.md
# t03_nes_controller

Polls two NES gamepads over their shared latch/clock serial protocol and publishes a packed button word with a one-cycle update strobe. It sits directly upstream of the MMIO interface: `NESData` and `NESConfirm` drive that block's inputs of the same names. The CPU reads the word through memory-mapped I/O. No CPU-side handshake is needed; polling is free-running.

## Interface
Parameters:
- `DIV`, default 60: system cycles per half bit period (6 µs at 10 MHz). Must be ≥ 4.
- `POLL_CYCLES`, default 166667: cycles from one poll start to the next (60 Hz). Must be > 18·DIV + 2.

Ports:
- `clk`  in  1: system clock, rising edge.
- `n_rst`  in  1: asynchronous, active-low reset.
- `nes_data1`  in  1: controller 1 serial data. Asynchronous, active-low (0 = pressed).
- `nes_data2`  in  1: controller 2 serial data. Same conventions as `nes_data1`.
- `nes_latch`  out  1: shared latch to both pads.
- `nes_clk`  out  1: shared shift clock to both pads. Idles high.
- `NESData`  out  32: packed button word.
  - [7:0] p1 held.
  - [15:8] p2 held.
  - [23:16] p1 newly pressed.
  - [31:24] p2 newly pressed.
- `NESConfirm`  out  1: single-cycle pulse when `NESData` has just been updated.

## Operation
- Button bit order (bit 0 first): A, B, Select, Start, Up, Down, Left, Right. Stored inverted, so 1 = pressed.
- Each data input passes through a 2-FF synchronizer before sampling.
- FSM states: IDLE → LATCH → CLK_LO → CLK_HI → DONE → IDLE.
  - **IDLE:** `nes_latch`=0, `nes_clk`=1. The poll timer counts; at `POLL_CYCLES`−1 it wraps to 0 and the FSM enters LATCH.
  - **LATCH:** `nes_latch`=1 for 2·DIV cycles. Bit 0 is sampled on the last LATCH cycle. Then go to CLK_LO with pulse index 1.
  - **CLK_LO:** `nes_clk`=0 for DIV cycles. For pulse p ∈ 2..8, bit p−1 is sampled on the last CLK_LO cycle. Then go to CLK_HI.
  - **CLK_HI:** `nes_clk`=1 for DIV cycles. If p < 8, increment p and go to CLK_LO; otherwise go to DONE.
  - **DONE:** one cycle. Load the held bits from both shift registers and compute the new-press bits as new & ~previous held, per controller. Assert `NESConfirm`, then return to IDLE.
- Exactly 8 clock pulses are produced per poll.
- The poll timer runs continuously in every state, so the poll period is exactly `POLL_CYCLES`.
- `NESData` is stable between DONE cycles. New-press bits reflect only the most recent poll; they are not sticky.
- Reset is asynchronous, and `n_rst` low aborts any poll in progress. All of the following take their reset values immediately:
  - `nes_latch`=0, `nes_clk`=1.
  - `NESData`=0, `NESConfirm`=0.
  - FSM = IDLE, timer = 0, shift registers = 0, synchronizers = 1 (released).

## Timing
- Let t0 be the first cycle with `nes_latch`=1.
  - Latch is high during t0 … t0+2·DIV−1.
  - Pulse p has its low phase starting at t0+2·DIV+(p−1)·2·DIV.
  - `NESData` updates and `NESConfirm`=1 on cycle t0+18·DIV.
- The first t0 occurs `POLL_CYCLES` cycles after `n_rst` deasserts.
- Successive t0 values are exactly `POLL_CYCLES` apart.
- Synchronizer latency is 2 cycles. This is absorbed because each sample is taken at the end of a phase of at least DIV ≥ 4 cycles.

## Configuration
- Macro `T03_NES_EDGE_EN`:
  - Defined: [31:16] carry the new-press bits described above.
  - Undefined: [31:16] are tied to 0, and no previous-state registers are built.

## Structure
- Package `t03_nes_pkg` holds:
  - The FSM state enum.
  - Button index constants `BTN_A`=0 … `BTN_RIGHT`=7.
  - Field offsets within `NESData` (P1_HELD=0, P2_HELD=8, P1_NEW=16, P2_NEW=24).
- Sub-module `t03_nes_shift` is instantiated twice, once per controller. It contains:
  - the 2-FF synchronizer,
  - the inversion,
  - an 8-bit capture register written at a bit index supplied by the parent on a sample strobe.
- The parent owns the FSM, the timers and the output registers.

## Test plan
All directed tests use DIV=4 and POLL_CYCLES=200 unless stated otherwise.
- **Reset:** hold `n_rst`=0 → `nes_latch`=0, `nes_clk`=1, `NESData`=0, `NESConfirm`=0. The first latch rises 200 cycles after release.
- **Waveform:** check one poll → latch high exactly 8 cycles. Then 8 `nes_clk` low pulses of 4 cycles each, each followed by 4 high cycles. `NESConfirm` is high on exactly t0+72.
- **Capture:** pad model has p1 holding A+Start and p2 holding Right → first poll gives `NESData`=0x80098009 with `T03_NES_EDGE_EN` defined. A second poll with the same buttons gives 0x00008009.
- **New press:** p2 adds B between polls → that poll gives `NESData`=0x02008209.
- **Reset mid-poll:** drop `n_rst` during pulse 5 → outputs return to reset values in the same cycle, and no `NESConfirm` is produced. Polling resumes 200 cycles after release.
- **Macro off:** rerun the capture test with `T03_NES_EDGE_EN` undefined → `NESData`=0x00008009 on both polls.
